pipelined_control_unit: RTL and testbench

Decodes the 7-bit opcode of the instruction in ID and carries the resulting control bundle through ID/EX, EX/MEM and MEM/WB registers, so each stage reads its own control without datapath-side pipeline registers. It adds jump/branch decode, x0-write suppression, stall/flush bubble insertion, and an ecall halt sequencer that drains the pipe before asserting `is_halted`. It sits beside the hazard-detection unit in the 5-stage pipelined core; opcode encodings come from `opcodes.v`.

---
 rtl/pipelined_control_unit_if.sv | 42 ++++
 rtl/pipelined_control_unit.sv | 164 ++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_control_unit_if.sv
// Control-unit bus: ID-side inputs from the hazard unit and the per-stage control bundle.
// The core/hazard side is the master, the control unit is the slave.
interface pipelined_control_unit_if;
  logic [6:0] part_of_inst;
  logic       id_valid;
  logic       id_rd_is_x0;
  logic       stall;
  logic       flush;
  logic       halt_req;

  logic       ex_valid;
  logic       ex_alu_src;
  logic       ex_is_jal;
  logic       ex_is_jalr;
  logic       ex_branch;
  logic       mem_valid;
  logic       mem_read;
  logic       mem_write;
  logic       wb_valid;
  logic       wb_write_enable;
  logic       wb_mem_to_reg;
  logic       wb_pc_to_reg;
  logic       id_is_ecall;
  logic       fetch_stop;
  logic       is_halted;

  modport master (
    output part_of_inst, id_valid, id_rd_is_x0, stall, flush, halt_req,
    input  ex_valid, ex_alu_src, ex_is_jal, ex_is_jalr, ex_branch,
    input  mem_valid, mem_read, mem_write,
    input  wb_valid, wb_write_enable, wb_mem_to_reg, wb_pc_to_reg,
    input  id_is_ecall, fetch_stop, is_halted
  );

  modport slave (
    input  part_of_inst, id_valid, id_rd_is_x0, stall, flush, halt_req,
    output ex_valid, ex_alu_src, ex_is_jal, ex_is_jalr, ex_branch,
    output mem_valid, mem_read, mem_write,
    output wb_valid, wb_write_enable, wb_mem_to_reg, wb_pc_to_reg,
    output id_is_ecall, fetch_stop, is_halted
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// Decodes the ID opcode and carries the control bundle through ID/EX, EX/MEM and MEM/WB,
// with stall/flush bubble insertion and an ecall halt sequencer that drains the pipe.
module pipelined_control_unit #(
  parameter int unsigned HALT_DRAIN  = 3,
  parameter bit          SUPPRESS_X0 = 1'b1
) (
  input logic                     clk,
  input logic                     reset,
  pipelined_control_unit_if.slave bus
);

  localparam logic [6:0] OP_ARITHMETIC     = 7'b0110011;
  localparam logic [6:0] OP_ARITHMETIC_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD           = 7'b0000011;
  localparam logic [6:0] OP_STORE          = 7'b0100011;
  localparam logic [6:0] OP_BRANCH         = 7'b1100011;
  localparam logic [6:0] OP_JAL            = 7'b1101111;
  localparam logic [6:0] OP_JALR           = 7'b1100111;
  localparam logic [6:0] OP_ECALL          = 7'b1110011;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic valid;
    logic alu_src;
    logic is_jal;
    logic is_jalr;
    logic branch;
    logic mem_read;
    logic mem_write;
    logic write_enable;
    logic mem_to_reg;
    logic pc_to_reg;
  } ex_ctrl_t;

  typedef struct packed {
    logic valid;
    logic mem_read;
    logic mem_write;
    logic write_enable;
    logic mem_to_reg;
    logic pc_to_reg;
  } mem_ctrl_t;

  typedef struct packed {
    logic valid;
    logic write_enable;
    logic mem_to_reg;
    logic pc_to_reg;
  } wb_ctrl_t;

  ex_ctrl_t  dec;
  ex_ctrl_t  id_ex_d, id_ex_q;
  mem_ctrl_t ex_mem_d, ex_mem_q;
  wb_ctrl_t  mem_wb_d, mem_wb_q;
  state_t    state_d, state_q;
  logic [3:0] cnt_d, cnt_q;
  logic      fetch_stop_d, fetch_stop_q;
  logic      is_halted_d, is_halted_q;
  logic      is_ecall_op;
  logic      accept;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    dec = '0;
    case (bus.part_of_inst)
      OP_ARITHMETIC:     dec.write_enable = 1'b1;
      OP_ARITHMETIC_IMM: begin dec.alu_src = 1'b1; dec.write_enable = 1'b1; end
      OP_LOAD: begin
        dec.alu_src      = 1'b1;
        dec.mem_read     = 1'b1;
        dec.mem_to_reg   = 1'b1;
        dec.write_enable = 1'b1;
      end
      OP_STORE:  begin dec.alu_src = 1'b1; dec.mem_write = 1'b1; end
      OP_BRANCH: dec.branch = 1'b1;
      OP_JAL: begin
        dec.alu_src = 1'b1; dec.is_jal = 1'b1; dec.pc_to_reg = 1'b1; dec.write_enable = 1'b1;
      end
      OP_JALR: begin
        dec.alu_src = 1'b1; dec.is_jalr = 1'b1; dec.pc_to_reg = 1'b1; dec.write_enable = 1'b1;
      end
      default: dec = '0;
    endcase
    if (SUPPRESS_X0 && bus.id_rd_is_x0) dec.write_enable = 1'b0;
    dec.valid = 1'b1;
  end

  assign is_ecall_op = (bus.part_of_inst == OP_ECALL);
  assign accept      = (state_q == RUN) && bus.id_valid && is_ecall_op &&
                       bus.halt_req && !bus.stall && !bus.flush;

  always_comb begin
    // Anything not a live, unstalled, non-ecall instruction in RUN enters EX as a bubble.
    if (!bus.id_valid || bus.stall || bus.flush || is_ecall_op || state_q != RUN) id_ex_d = '0;
    else id_ex_d = dec;
    ex_mem_d = '{valid: id_ex_q.valid, mem_read: id_ex_q.mem_read, mem_write: id_ex_q.mem_write,
                 write_enable: id_ex_q.write_enable, mem_to_reg: id_ex_q.mem_to_reg,
                 pc_to_reg: id_ex_q.pc_to_reg};
    mem_wb_d = '{valid: ex_mem_q.valid, write_enable: ex_mem_q.write_enable,
                 mem_to_reg: ex_mem_q.mem_to_reg, pc_to_reg: ex_mem_q.pc_to_reg};
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fetch_stop_d = fetch_stop_q;
    is_halted_d  = is_halted_q;
    case (state_q)
      RUN: if (accept) begin
        state_d      = DRAIN;
        cnt_d        = 4'(HALT_DRAIN);
        fetch_stop_d = 1'b1;
      end
      DRAIN: if (cnt_q <= 4'd1) begin
        state_d     = HALTED;
        cnt_d       = 4'd0;
        is_halted_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_ex_q      <= '0;
      ex_mem_q     <= '0;
      mem_wb_q     <= '0;
      state_q      <= RUN;
      cnt_q        <= 4'd0;
      fetch_stop_q <= 1'b0;
      is_halted_q  <= 1'b0;
    end else begin
      id_ex_q      <= id_ex_d;
      ex_mem_q     <= ex_mem_d;
      mem_wb_q     <= mem_wb_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fetch_stop_q <= fetch_stop_d;
      is_halted_q  <= is_halted_d;
    end
  end

  assign bus.ex_valid        = id_ex_q.valid;
  assign bus.ex_alu_src      = id_ex_q.alu_src;
  assign bus.ex_is_jal       = id_ex_q.is_jal;
  assign bus.ex_is_jalr      = id_ex_q.is_jalr;
  assign bus.ex_branch       = id_ex_q.branch;
  assign bus.mem_valid       = ex_mem_q.valid;
  assign bus.mem_read        = ex_mem_q.mem_read;
  assign bus.mem_write       = ex_mem_q.mem_write;
  assign bus.wb_valid        = mem_wb_q.valid;
  assign bus.wb_write_enable = mem_wb_q.write_enable;
  assign bus.wb_mem_to_reg   = mem_wb_q.mem_to_reg;
  assign bus.wb_pc_to_reg    = mem_wb_q.pc_to_reg;
  assign bus.id_is_ecall     = bus.id_valid && is_ecall_op;
  assign bus.fetch_stop      = fetch_stop_q;
  assign bus.is_halted       = is_halted_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench: directed instructions push hand-computed per-stage expectations;
// a negedge monitor pops and compares whenever a stage presents a valid bundle.
module tb_pipelined_control_unit;

  localparam logic [6:0] ADD   = 7'b0110011;
  localparam logic [6:0] ADDI  = 7'b0010011;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] ECALL = 7'b1110011;

  typedef struct {
    int         cyc;
    logic [3:0] ex;   // {alu_src, is_jal, is_jalr, branch}
    logic [1:0] mem;  // {mem_read, mem_write}
    logic [2:0] wb;   // {write_enable, mem_to_reg, pc_to_reg}
    logic       web;  // write_enable of the SUPPRESS_X0 = 0 instance
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_errors;
  exp_t ex_q[$];
  exp_t mem_q[$];
  exp_t wb_q[$];

  pipelined_control_unit_if bus_a ();
  pipelined_control_unit_if bus_b ();

  pipelined_control_unit #(.HALT_DRAIN(3), .SUPPRESS_X0(1'b1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave));
  pipelined_control_unit #(.HALT_DRAIN(3), .SUPPRESS_X0(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave));

  assign bus_b.part_of_inst = bus_a.part_of_inst;
  assign bus_b.id_valid     = bus_a.id_valid;
  assign bus_b.id_rd_is_x0  = bus_a.id_rd_is_x0;
  assign bus_b.stall        = bus_a.stall;
  assign bus_b.flush        = bus_a.flush;
  assign bus_b.halt_req     = bus_a.halt_req;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (bus_a.ex_valid) begin
        if (ex_q.size() == 0) check("ex_unexpected_valid", 1, 0);
        else begin
          e = ex_q.pop_front();
          check("ex_latency", cyc, e.cyc + 1);
          check("ex_bundle", {bus_a.ex_alu_src, bus_a.ex_is_jal, bus_a.ex_is_jalr, bus_a.ex_branch}, e.ex);
        end
      end
      if (bus_a.mem_valid) begin
        if (mem_q.size() == 0) check("mem_unexpected_valid", 1, 0);
        else begin
          e = mem_q.pop_front();
          check("mem_latency", cyc, e.cyc + 2);
          check("mem_bundle", {bus_a.mem_read, bus_a.mem_write}, e.mem);
        end
      end
      if (bus_a.wb_valid) begin
        if (wb_q.size() == 0) check("wb_unexpected_valid", 1, 0);
        else begin
          e = wb_q.pop_front();
          check("wb_latency", cyc, e.cyc + 3);
          check("wb_bundle", {bus_a.wb_write_enable, bus_a.wb_mem_to_reg, bus_a.wb_pc_to_reg}, e.wb);
          check("wb_valid_nosup", bus_b.wb_valid, 1);
          check("wb_we_nosup", bus_b.wb_write_enable, e.web);
        end
      end
    end
  end

  task automatic issue(input logic [6:0] op, input logic rd0, input logic [3:0] ex_e,
                       input logic [1:0] mem_e, input logic [2:0] wb_e, input logic web_e,
                       input bit accepted);
    exp_t e;
    bus_a.part_of_inst = op;
    bus_a.id_valid     = 1'b1;
    bus_a.id_rd_is_x0  = rd0;
    if (accepted) begin
      e = '{cyc: cyc, ex: ex_e, mem: mem_e, wb: wb_e, web: web_e};
      ex_q.push_back(e);
      mem_q.push_back(e);
      wb_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus_a.id_valid = 1'b0;
    bus_a.stall    = 1'b0;
    bus_a.flush    = 1'b0;
    bus_a.halt_req = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {bus_a.ex_valid, bus_a.ex_alu_src, bus_a.ex_is_jal, bus_a.ex_is_jalr,
                 bus_a.ex_branch, bus_a.mem_valid, bus_a.mem_read, bus_a.mem_write,
                 bus_a.wb_valid, bus_a.wb_write_enable, bus_a.wb_mem_to_reg,
                 bus_a.wb_pc_to_reg, bus_a.fetch_stop, bus_a.is_halted}, 0);
  endtask

  task automatic pulse_reset();
    idle(0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_all_zero("sync_reset_outputs");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc = 0;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus_a.part_of_inst = 7'd0;
    bus_a.id_valid     = 1'b0;
    bus_a.id_rd_is_x0  = 1'b0;
    bus_a.stall        = 1'b0;
    bus_a.flush        = 1'b0;
    bus_a.halt_req     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");

    bus_a.part_of_inst = ECALL;
    bus_a.id_valid = 1'b1;
    #1 check("id_is_ecall_hi", bus_a.id_is_ecall, 1);
    bus_a.id_valid = 1'b0;
    #1 check("id_is_ecall_invalid", bus_a.id_is_ecall, 0);
    bus_a.id_valid = 1'b1;
    bus_a.part_of_inst = ADD;
    #1 check("id_is_ecall_add", bus_a.id_is_ecall, 0);
    bus_a.id_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    // Back-to-back decode table; last field pair is (SUPPRESS_X0=1, SUPPRESS_X0=0) write enable.
    issue(ADD,   1'b0, 4'b0000, 2'b00, 3'b100, 1'b1, 1);
    issue(ADDI,  1'b0, 4'b1000, 2'b00, 3'b100, 1'b1, 1);
    issue(STORE, 1'b0, 4'b1000, 2'b01, 3'b000, 1'b0, 1);
    issue(BR,    1'b0, 4'b0001, 2'b00, 3'b000, 1'b0, 1);
    issue(JALR,  1'b0, 4'b1010, 2'b00, 3'b101, 1'b1, 1);
    issue(JAL,   1'b1, 4'b1100, 2'b00, 3'b001, 1'b1, 1);
    issue(ADD,   1'b1, 4'b0000, 2'b00, 3'b000, 1'b1, 1);
    issue(7'h7F, 1'b0, 4'b0000, 2'b00, 3'b000, 1'b0, 1);
    idle(4);

    // Load-use stall: stalled slot is a bubble, then the held LOAD proceeds.
    bus_a.stall = 1'b1;
    issue(LOAD, 1'b0, 4'b1000, 2'b10, 3'b110, 1'b1, 0);
    check("stall_bubble_ex", bus_a.ex_valid, 0);
    bus_a.stall = 1'b0;
    issue(LOAD, 1'b0, 4'b1000, 2'b10, 3'b110, 1'b1, 1);
    check("load_after_stall_ex", bus_a.ex_valid, 1);
    idle(4);

    bus_a.stall = 1'b1;
    bus_a.flush = 1'b1;
    issue(ADD, 1'b0, 4'b0000, 2'b00, 3'b100, 1'b1, 0);
    check("stall_flush_bubble", bus_a.ex_valid, 0);
    idle(1);

    // Halt with flush on the first ecall edge; an older ADD drains meanwhile.
    issue(ADD, 1'b0, 4'b0000, 2'b00, 3'b100, 1'b1, 1);
    bus_a.halt_req = 1'b1;
    bus_a.flush = 1'b1;
    issue(ECALL, 1'b0, 4'b0000, 2'b00, 3'b000, 1'b0, 0);
    check("flush_ecall_no_stop", bus_a.fetch_stop, 0);
    bus_a.flush = 1'b0;
    issue(ECALL, 1'b0, 4'b0000, 2'b00, 3'b000, 1'b0, 0);
    check("accept_fetch_stop", bus_a.fetch_stop, 1);
    check("accept_not_halted", bus_a.is_halted, 0);
    bus_a.halt_req = 1'b0;
    bus_a.stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      issue(ADD, 1'b0, 4'b0000, 2'b00, 3'b100, 1'b1, 0);
      check($sformatf("drain_halted_edge%0d", i), bus_a.is_halted, (i == 3) ? 1 : 0);
      check("drain_ex_bubble", bus_a.ex_valid, 0);
    end
    idle(0);
    for (int i = 0; i < 12; i++) begin
      idle(1);
      check("halted_sticky", {bus_a.is_halted, bus_a.fetch_stop}, 2'b11);
    end

    pulse_reset();

    // Ecall under stall for two edges, then accepted.
    bus_a.halt_req = 1'b1;
    bus_a.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      issue(ECALL, 1'b0, 4'b0000, 2'b00, 3'b000, 1'b0, 0);
      check("stalled_ecall_no_stop", bus_a.fetch_stop, 0);
    end
    bus_a.stall = 1'b0;
    issue(ECALL, 1'b0, 4'b0000, 2'b00, 3'b000, 1'b0, 0);
    check("stall_accept_fetch_stop", bus_a.fetch_stop, 1);
    for (int i = 1; i <= 3; i++) begin
      idle(1);
      check($sformatf("stall_halt_edge%0d", i), bus_a.is_halted, (i == 3) ? 1 : 0);
    end

    pulse_reset();

    // Asynchronous reset in the middle of DRAIN.
    bus_a.halt_req = 1'b1;
    issue(ECALL, 1'b0, 4'b0000, 2'b00, 3'b000, 1'b0, 0);
    check("async_pre_accept", bus_a.fetch_stop, 1);
    idle(1);
    check("async_pre_drain", {bus_a.fetch_stop, bus_a.is_halted}, 2'b10);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset_outputs");
    #2 reset = 1'b0;
    @(posedge clk); #1;
    check("after_async_run", {bus_a.fetch_stop, bus_a.is_halted}, 2'b00);
    issue(ADD, 1'b0, 4'b0000, 2'b00, 3'b100, 1'b1, 1);
    check("after_async_add_ex", bus_a.ex_valid, 1);
    idle(4);

    check("ex_q_drained", ex_q.size(), 0);
    check("mem_q_drained", mem_q.size(), 0);
    check("wb_q_drained", wb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
